// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus data-memory port of the load/store unit.
// Signal names carry the direction as seen from lsu_ctrl.
//   req_*   : execute-stage request (valid/ready, we, funct3, addr, wdata)
//   resp_*  : one-cycle completion pulse with extended load data and error flag
//   stall_o : pipeline stall while the unit is busy
//   mem_*   : data-memory port (write enable, size select, address, write/read data)
// Modports: slave = lsu_ctrl side, master = requester/memory environment side.
interface lsu_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [2:0]        req_funct3_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [ADDR_W-1:0] req_wdata_i;
   logic              resp_valid_o;
   logic [ADDR_W-1:0] resp_rdata_o;
   logic              resp_err_o;
   logic              stall_o;
   logic              mem_rw_o;
   logic [1:0]        mem_sec_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [ADDR_W-1:0] mem_wdata_o;
   logic [ADDR_W-1:0] mem_data_i;

   modport slave (
      input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_data_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o,
      output mem_rw_o, mem_sec_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_data_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o,
      input  mem_rw_o, mem_sec_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between execute and data-memory stage.
// Accepts one request at a time (valid/ready), validates it (funct3, alignment, range),
// drives the memory port for one cycle, captures registered read data one cycle later and
// sign/zero-extends it per RISC-V funct3. Rejected requests never reach memory.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_ctrl_if.slave (request, response, stall, memory port)
// Optional feature, macro LSU_ERR_STICKY_EN:
//   err_sticky_o / err_addr_o : sticky flag and address of the first rejected request
//   err_clr_i                 : clears both; a simultaneous new error takes precedence
module lsu_ctrl #(
   parameter int unsigned MEM_TOP = 20,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_ctrl_if.slave         bus
`ifdef LSU_ERR_STICKY_EN
   ,
   output logic              err_sticky_o,
   output logic [ADDR_W-1:0] err_addr_o,
   input  logic              err_clr_i
`endif
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

   localparam logic [ADDR_W:0] MemTopExt = (ADDR_W+1)'(MEM_TOP);

   state_e            state_q, state_d;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q, wdata_q, rdata_q, ext_data;
   logic              err_q;
   logic              accept, chk_err, illegal, misaligned, out_of_range;
   logic [ADDR_W:0]   size_m1, last_byte;

   assign accept = (state_q == StIdle) && bus.req_valid_i;

   // Request check on the live inputs; the result is used only at the accept edge.
   always_comb begin
      size_m1 = '0;
      case (bus.req_funct3_i[1:0])
         2'b00:   size_m1 = (ADDR_W+1)'(0);
         2'b01:   size_m1 = (ADDR_W+1)'(1);
         default: size_m1 = (ADDR_W+1)'(3);
      endcase
      // One extra bit so an access near the top of the address space cannot wrap.
      last_byte    = {1'b0, bus.req_addr_i} + size_m1;
      out_of_range = last_byte > MemTopExt;
      if (bus.req_we_i) begin
         illegal = bus.req_funct3_i[2] || (bus.req_funct3_i[1:0] == 2'b11);
      end else begin
         illegal = (bus.req_funct3_i[1:0] == 2'b11) || (bus.req_funct3_i == 3'b110);
      end
      misaligned = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                   ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
      chk_err    = illegal || misaligned || out_of_range;
   end

   // Load data extension, selected by the latched funct3.
   always_comb begin
      ext_data = bus.mem_data_i;
      case (funct3_q)
         3'b000:  ext_data = {{(ADDR_W-8){bus.mem_data_i[7]}}, bus.mem_data_i[7:0]};
         3'b001:  ext_data = {{(ADDR_W-16){bus.mem_data_i[15]}}, bus.mem_data_i[15:0]};
         3'b100:  ext_data = {{(ADDR_W-8){1'b0}}, bus.mem_data_i[7:0]};
         3'b101:  ext_data = {{(ADDR_W-16){1'b0}}, bus.mem_data_i[15:0]};
         default: ext_data = bus.mem_data_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (bus.req_valid_i) state_d = chk_err ? StResp : StIssue;
         StIssue:   state_d = we_q ? StResp : StCapture;
         StCapture: state_d = StResp;
         StResp:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= bus.req_we_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i;
            wdata_q  <= bus.req_wdata_i;
         end
         // Response registers change only on the edge that enters RESP, so they hold
         // the previous response until the next one is presented.
         if (accept && chk_err) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else if ((state_q == StIssue) && we_q) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end else if (state_q == StCapture) begin
            rdata_q <= ext_data;
            err_q   <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.req_ready_o  = (state_q == StIdle);
      bus.stall_o      = (state_q != StIdle);
      bus.resp_valid_o = (state_q == StResp);
      bus.resp_rdata_o = rdata_q;
      bus.resp_err_o   = err_q;
      // Write enable is decoded from state only, so reset removes it asynchronously.
      bus.mem_rw_o     = (state_q == StIssue) && we_q;
      bus.mem_sec_o    = 2'b11;
      if ((state_q == StIssue) || (state_q == StCapture)) bus.mem_sec_o = funct3_q[1:0];
      bus.mem_addr_o   = addr_q;
      bus.mem_wdata_o  = wdata_q;
   end

`ifdef LSU_ERR_STICKY_EN
   logic              err_sticky_q;
   logic [ADDR_W-1:0] err_addr_q;
   logic              new_err;

   assign new_err = accept && chk_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky_q <= 1'b0;
         err_addr_q   <= '0;
      end else if (new_err) begin
         err_sticky_q <= 1'b1;
         // A clear in the same cycle frees the slot for the new error's address.
         if (!err_sticky_q || err_clr_i) err_addr_q <= bus.req_addr_i;
      end else if (err_clr_i) begin
         err_sticky_q <= 1'b0;
         err_addr_q   <= '0;
      end
   end

   assign err_sticky_o = err_sticky_q;
   assign err_addr_o   = err_addr_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
   localparam int MEM_TOP = 20;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  sec;
   } wr_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mem_init_done = 1'b0;

   logic [7:0] mem_m   [0:MEM_TOP];
   logic [7:0] ref_mem [0:MEM_TOP];
   resp_t      sb_q [$];
   wr_t        wr_q [$];

   lsu_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef LSU_ERR_STICKY_EN
   logic        err_sticky;
   logic [31:0] err_addr;
   logic        err_clr;
   lsu_ctrl #(.MEM_TOP(MEM_TOP), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .err_sticky_o(err_sticky), .err_addr_o(err_addr), .err_clr_i(err_clr)
   );
`else
   lsu_ctrl #(.MEM_TOP(MEM_TOP), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   // Data memory: writes on rw, registered LSB-aligned read data one cycle after issue.
   function automatic logic [31:0] mem_read(input logic [31:0] addr, input logic [1:0] sec);
      logic [31:0] r;
      longint      idx;
      r = 0;
      for (int k = 0; k < (1 << sec); k++) begin
         idx = longint'(addr) + k;
         if (idx <= MEM_TOP) r = r | (32'(mem_m[int'(idx)]) << (8 * k));
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i <= MEM_TOP; i++) mem_m[i] <= init_byte(i);
         mem_init_done <= 1'b1;
      end else if (bus.mem_rw_o) begin
         for (int k = 0; k < (1 << bus.mem_sec_o); k++) begin
            if (longint'(bus.mem_addr_o) + k <= MEM_TOP)
               mem_m[int'(bus.mem_addr_o) + k] <= 8'(bus.mem_wdata_o >> (8 * k));
         end
      end else if (bus.mem_sec_o != 2'b11) begin
         bus.mem_data_i <= mem_read(bus.mem_addr_o, bus.mem_sec_o);
      end
   end

   // Reference model: what an architectural load/store should return, from the rules alone.
   function automatic void ref_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic err,
                                   output logic [31:0] rdata);
      int     size;
      bit     legal;
      longint v;
      size  = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || (addr % size != 0) || (longint'(addr) + size - 1 > MEM_TOP);
      rdata = 0;
      if (!err && we) begin
         for (int k = 0; k < size; k++) ref_mem[int'(addr) + k] = 8'(wdata >> (8 * k));
      end else if (!err) begin
         v = 0;
         for (int k = 0; k < size; k++) v = v + longint'(ref_mem[int'(addr) + k]) * (1 << (8 * k));
         if (f3 == 3'd0 && v >= 128) v = v - 256;
         if (f3 == 3'd1 && v >= 32768) v = v - 65536;
         rdata = 32'(v);
      end
   endfunction

   // Issue one request starting at a negedge; returns at the negedge where ready is back.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
      int          n;
      int          lat;
      logic        e;
      logic [31:0] rd;
      resp_t       r;
      wr_t         w;
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_funct3_i = f3;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wdata;
      n = 0;
      while (!bus.req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready_o) begin
         fail_now("accept_timeout");
         bus.req_valid_i = 1'b0;
         return;
      end
      ref_req(we, f3, addr, wdata, e, rd);
      lat     = e ? 1 : (we ? 2 : 3);
      r.err   = e;
      r.rdata = rd;
      r.cyc   = cyc + lat;
      sb_q.push_back(r);
      if (we && !e) begin
         w.addr = addr;
         w.data = wdata;
         w.sec  = f3[1:0];
         wr_q.push_back(w);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid_i = 1'b0;
      @(negedge clk);
      n = 0;
      while (!bus.req_ready_o && n < 20) begin
         chk("stall_while_busy", 32'(bus.stall_o), 32'd1);
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(n), 32'(lat));
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.resp_valid_o) begin
            if (sb_q.size() == 0) begin
               fail_now("unexpected_resp");
            end else begin
               resp_t r;
               r = sb_q.pop_front();
               chk("resp_err", 32'(bus.resp_err_o), 32'(r.err));
               chk("resp_rdata", bus.resp_rdata_o, r.rdata);
               chk("resp_cycle", 32'(cyc), 32'(r.cyc));
            end
         end
         if (bus.mem_rw_o) begin
            if (wr_q.size() == 0) begin
               fail_now("unexpected_mem_write");
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("wr_addr", bus.mem_addr_o, w.addr);
               chk("wr_data", bus.mem_wdata_o, w.data);
               chk("wr_sec", 32'(bus.mem_sec_o), 32'(w.sec));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n            = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_funct3_i = 3'b000;
      bus.req_addr_i   = 0;
      bus.req_wdata_i  = 0;
`ifdef LSU_ERR_STICKY_EN
      err_clr = 1'b0;
`endif
      for (int i = 0; i <= MEM_TOP; i++) ref_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_rdata", bus.resp_rdata_o, 32'd0);
      chk("rst_err", 32'(bus.resp_err_o), 32'd0);
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      chk("rst_rw", 32'(bus.mem_rw_o), 32'd0);
      chk("rst_sec", 32'(bus.mem_sec_o), 32'd3);
      chk("rst_addr", bus.mem_addr_o, 32'd0);
      chk("rst_wdata", bus.mem_wdata_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: store, then loads of known data with each extension.
      do_req(1'b1, 3'b010, 32'd4, 32'h1122_3344, 1'b0);
      do_req(1'b1, 3'b000, 32'd3, 32'h0000_0080, 1'b0);
      do_req(1'b0, 3'b000, 32'd3, 32'd0, 1'b0);
      do_req(1'b0, 3'b100, 32'd3, 32'd0, 1'b0);
      do_req(1'b1, 3'b001, 32'd2, 32'h0000_F00D, 1'b0);
      do_req(1'b0, 3'b001, 32'd2, 32'd0, 1'b0);
      do_req(1'b0, 3'b101, 32'd2, 32'd0, 1'b0);
      do_req(1'b1, 3'b010, 32'd0, 32'h0034_5678, 1'b0);
      do_req(1'b0, 3'b010, 32'd0, 32'd0, 1'b0);
      do_req(1'b0, 3'b010, 32'd4, 32'd0, 1'b0);

      // Rejections: misaligned, out of range, wrap-around, illegal funct3.
      do_req(1'b0, 3'b010, 32'd2, 32'd0, 1'b0);
      do_req(1'b1, 3'b001, 32'd1, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b0, 3'b010, 32'd20, 32'd0, 1'b0);
      do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 1'b0);
      do_req(1'b0, 3'b011, 32'd0, 32'd0, 1'b0);
      do_req(1'b1, 3'b100, 32'd0, 32'h5555_5555, 1'b0);
      do_req(1'b0, 3'b010, 32'd16, 32'd0, 1'b0);
      do_req(1'b0, 3'b000, 32'd20, 32'd0, 1'b0);

      // Back-to-back loads with valid held high.
      do_req(1'b0, 3'b010, 32'd0, 32'd0, 1'b1);
      do_req(1'b0, 3'b001, 32'd6, 32'd0, 1'b1);
      do_req(1'b0, 3'b100, 32'd9, 32'd0, 1'b0);

      // Reset during the ISSUE cycle of a store.
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = 1'b1;
      bus.req_funct3_i = 3'b000;
      bus.req_addr_i   = 32'd5;
      bus.req_wdata_i  = 32'h0000_00AB;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      chk("issue_rw_before_rst", 32'(bus.mem_rw_o), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rw", 32'(bus.mem_rw_o), 32'd0);
      chk("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
      chk("post_rst_stall", 32'(bus.stall_o), 32'd0);
      chk("post_rst_sec", 32'(bus.mem_sec_o), 32'd3);
      do_req(1'b0, 3'b000, 32'd5, 32'd0, 1'b0);

`ifdef LSU_ERR_STICKY_EN
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("sticky_cleared0", 32'(err_sticky), 32'd0);
      do_req(1'b0, 3'b010, 32'd6, 32'd0, 1'b0);
      do_req(1'b0, 3'b001, 32'd9, 32'd0, 1'b0);
      chk("sticky_set", 32'(err_sticky), 32'd1);
      chk("sticky_addr", err_addr, 32'd6);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("sticky_cleared", 32'(err_sticky), 32'd0);
      chk("sticky_addr_cleared", err_addr, 32'd0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 99) < 88) a = 32'($urandom_range(0, MEM_TOP + 3));
         else a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                ($urandom_range(0, 1) == 1) && (i != 199));
      end
      bus.req_valid_i = 1'b0;

      repeat (10) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("wr_drained", 32'(wr_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
